// File: rtl/booth_seq_mult12.sv
// Sequential radix-2 Booth multiplier.
// A WIDTH-bit carry-lookahead adder (no carry-in, no carry-out) adds either
// +M or a pre-negated -M to the partial accumulator once per iteration.
// After WIDTH iterations a signed 2*WIDTH product is registered and done pulses.
//
// Handshake (start/busy/done): start is sampled only on an edge where busy==0,
// and the operands are captured on that same edge. busy stays high until the
// edge that registers the result. done is a one-cycle pulse on the cycle that
// follows that edge, and busy is already low in that cycle. Holding start high
// on the done cycle therefore launches the next operation back to back.
// product and err hold their value until the next completion. The exception is
// err, which clears when the next operation is accepted.

// Combinational WIDTH-bit carry-lookahead adder built from 4-bit lookahead groups.
// The result wraps modulo 2^WIDTH. WIDTH must be a multiple of 4.
module booth_cla_adder #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic             gc;
  logic             gg;
  logic             gp;

  // Generate/propagate per bit. Carries are expanded inside each group, and the group carry is chained.
  always_comb begin
    g  = i1 & i2;
    p  = i1 ^ i2;
    c  = '0;
    gc = 1'b0;
    gg = 1'b0;
    gp = 1'b0;
    for (int grp = 0; grp < WIDTH / 4; grp++) begin
      c[grp*4]   = gc;
      c[grp*4+1] = g[grp*4] | (p[grp*4] & gc);
      c[grp*4+2] = g[grp*4+1] | (p[grp*4+1] & g[grp*4])
                 | (p[grp*4+1] & p[grp*4] & gc);
      c[grp*4+3] = g[grp*4+2] | (p[grp*4+2] & g[grp*4+1])
                 | (p[grp*4+2] & p[grp*4+1] & g[grp*4])
                 | (p[grp*4+2] & p[grp*4+1] & p[grp*4] & gc);
      gg = g[grp*4+3] | (p[grp*4+3] & g[grp*4+2])
         | (p[grp*4+3] & p[grp*4+2] & g[grp*4+1])
         | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & g[grp*4]);
      gp = p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & p[grp*4];
      gc = gg | (gp & gc);
    end
    sum = p ^ c;
  end

endmodule

// Booth control and datapath around the adder.
module booth_seq_mult12 #(
  parameter int WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             last;

  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] m_neg;
  logic             m_min;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_m1;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] add_b;
  logic             use_adder;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             q_m1_nxt;

  booth_cla_adder #(.WIDTH(WIDTH)) u_adder (
    .i1  (a_reg),
    .i2  (add_b),
    .sum (add_sum)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state. load marks the accepting edge, last marks the WIDTH-th iteration.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (count == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Booth recoding of {Q[0], q_m1}: 01 adds M, 10 adds -M, 00/11 bypass the adder.
  always_comb begin
    add_b     = '0;
    use_adder = 1'b0;
    case ({q_reg[0], q_m1})
      2'b01: begin
        add_b     = m_reg;
        use_adder = 1'b1;
      end
      2'b10: begin
        add_b     = m_neg;
        use_adder = 1'b1;
      end
      default: begin
        add_b     = '0;
        use_adder = 1'b0;
      end
    endcase
  end

  // Arithmetic right shift of {acc, Q, q_m1}, replicating the sign of acc.
  always_comb begin
    acc      = use_adder ? add_sum : a_reg;
    a_nxt    = {acc[WIDTH-1], acc[WIDTH-1:1]};
    q_nxt    = {acc[0], q_reg[WIDTH-1:1]};
    q_m1_nxt = q_reg[0];
  end

  // Operand capture, per-iteration update, and result registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg   <= '0;
      m_neg   <= '0;
      m_min   <= 1'b0;
      a_reg   <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
      product <= '0;
      err     <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        m_reg <= multiplicand;
        m_neg <= ~multiplicand + WIDTH'(1);
        m_min <= (multiplicand == MOST_NEG);
        a_reg <= '0;
        q_reg <= multiplier;
        q_m1  <= 1'b0;
        count <= '0;
        err   <= 1'b0;
      end else if (state == RUN) begin
        a_reg <= a_nxt;
        q_reg <= q_nxt;
        q_m1  <= q_m1_nxt;
        count <= count + CW'(1);
        if (last) begin
          // -M cannot be represented for the most negative M, so the result is flagged and zeroed.
          product <= m_min ? '0 : {a_nxt, q_nxt};
          err     <= m_min;
        end
      end
    end
  end

endmodule
